// File: rtl/spi_tft_pkg.sv
// Shared types and defaults for the SPI TFT pixel path.
// Holds state encodings, pixel width and default screen geometry.
package spi_tft_pkg;

  localparam int RGB565_W     = 16;
  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 240;

  typedef enum logic [1:0] {
    ST_WAIT_FSYNC = 2'd0,
    ST_ALIGN      = 2'd1,
    ST_RUN        = 2'd2
  } state_t;

endpackage

// File: rtl/spi_tft_pixel_fifo.sv
// Small synchronous FIFO with combinational head peek.
// Depth must be a power of two so the pointers wrap naturally.
module spi_tft_pixel_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/spi_tft_pixel_feeder.sv
// Buffers RGB565 pixels and serialises them, high byte first,
// to the TFT driver; realigns on frame sync, fills on starvation.
import spi_tft_pkg::*;

module spi_tft_pixel_feeder #(
  parameter int          SCREEN_WIDTH  = DEF_SCREEN_W,
  parameter int          SCREEN_HEIGHT = DEF_SCREEN_H,
  parameter int          FIFO_DEPTH    = 16,
  parameter logic [15:0] FILL_COLOR    = 16'h0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] pix_data_i,
  input  logic        pix_sof_i,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  output logic [7:0]  spi_screen_flush_data_o,
  input  logic        spi_screen_flush_updte_i,
  input  logic        spi_screen_flush_fsync_i,
  output logic        frame_done_o,
  output logic        sof_err_o,
  output logic [15:0] underflow_cnt_o,
  input  logic        err_clr_i
);

  localparam int PIX_N = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int CW    = (PIX_N > 1) ? $clog2(PIX_N) : 1;
  localparam logic [CW-1:0] LAST_PIX = CW'(PIX_N - 1);

  logic [RGB565_W:0]   head;
  logic [RGB565_W-1:0] head_pix;
  logic                head_sof;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic                ready_q;

  state_t              state;
  logic [RGB565_W-1:0] cur_pix;
  logic                byte_sel;
  logic                fill_mode;
  logic [CW-1:0]       pix_cnt;
  logic                last_pix;
  logic [7:0]          data_q;
  logic                frame_done_q;
  logic                sof_err_q;
  logic [15:0]         uf_cnt;
  logic                uf_inc;
  logic                err_set;
  logic                upd;
  logic                fsync;

  assign upd      = spi_screen_flush_updte_i;
  assign fsync    = spi_screen_flush_fsync_i;
  assign head_sof = head[RGB565_W];
  assign head_pix = head[RGB565_W-1:0];
  assign last_pix = (pix_cnt == LAST_PIX);

  // ready stays low until the first clock out of reset
  assign pix_ready_o = ready_q && !fifo_full;
  assign fifo_push   = pix_valid_i && pix_ready_o;

  assign spi_screen_flush_data_o = data_q;
  assign frame_done_o            = frame_done_q;
  assign sof_err_o               = sof_err_q;
  assign underflow_cnt_o         = uf_cnt;

  spi_tft_pixel_fifo #(
    .WIDTH (RGB565_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .push    (fifo_push),
    .wdata   ({pix_sof_i, pix_data_i}),
    .pop     (fifo_pop),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    fifo_pop = 1'b0;
    uf_inc   = 1'b0;
    err_set  = 1'b0;
    if (fsync) begin
      err_set = (state == ST_RUN) && (pix_cnt != '0);
    end else if (state == ST_ALIGN) begin
      if (upd) uf_inc   = 1'b1;
      else     fifo_pop = !fifo_empty;
    end else if (state == ST_RUN && upd &&
                 byte_sel && !last_pix) begin
      unique case (1'b1)
        fill_mode:
          fifo_pop = 1'b0;
        !fill_mode && fifo_empty:
          uf_inc = 1'b1;
        !fill_mode && !fifo_empty && head_sof:
          err_set = 1'b1;
        default:
          fifo_pop = 1'b1;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= ST_WAIT_FSYNC;
      cur_pix      <= FILL_COLOR;
      byte_sel     <= 1'b0;
      fill_mode    <= 1'b0;
      pix_cnt      <= '0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
      uf_cnt       <= '0;
      ready_q      <= 1'b0;
    end else begin
      ready_q      <= 1'b1;
      frame_done_q <= 1'b0;
      data_q <= byte_sel ? cur_pix[7:0] : cur_pix[15:8];
      if (err_clr_i) begin
        sof_err_q <= 1'b0;
        uf_cnt    <= '0;
      end else begin
        if (err_set) sof_err_q <= 1'b1;
        if (uf_inc && uf_cnt != 16'hFFFF)
          uf_cnt <= uf_cnt + 16'd1;
      end
      if (fsync) begin
        state     <= ST_ALIGN;
        byte_sel  <= 1'b0;
        pix_cnt   <= '0;
        fill_mode <= 1'b0;
      end else begin
        case (state)
          ST_ALIGN: begin
            if (upd) begin
              cur_pix  <= FILL_COLOR;
              byte_sel <= 1'b1;
              pix_cnt  <= '0;
              state    <= ST_RUN;
            end else if (!fifo_empty && head_sof) begin
              cur_pix  <= head_pix;
              byte_sel <= 1'b0;
              pix_cnt  <= '0;
              state    <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (upd) begin
              if (!byte_sel) begin
                byte_sel <= 1'b1;
              end else if (last_pix) begin
                frame_done_q <= 1'b1;
                cur_pix      <= FILL_COLOR;
                byte_sel     <= 1'b0;
                state        <= ST_WAIT_FSYNC;
              end else begin
                pix_cnt  <= pix_cnt + CW'(1);
                byte_sel <= 1'b0;
                cur_pix  <= fifo_pop ? head_pix : FILL_COLOR;
                // an early sof holds the rest of the frame on fill
                if (err_set) fill_mode <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_tft_pixel_feeder.sv
// Directed bench for spi_tft_pixel_feeder on a 4x2 screen,
// 8-deep FIFO and a distinctive fill colour.
module tb_spi_tft_pixel_feeder;

  localparam logic [15:0] FILL = 16'hBEEF;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [15:0] pix_data = '0;
  logic        pix_sof = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  flush_data;
  logic        updte = 1'b0;
  logic        fsync = 1'b0;
  logic        frame_done;
  logic        sof_err;
  logic [15:0] uf_cnt;
  logic        err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  spi_tft_pixel_feeder #(
    .SCREEN_WIDTH  (4),
    .SCREEN_HEIGHT (2),
    .FIFO_DEPTH    (8),
    .FILL_COLOR    (FILL)
  ) dut (
    .sys_clk                  (sys_clk),
    .sys_rst                  (sys_rst),
    .pix_data_i               (pix_data),
    .pix_sof_i                (pix_sof),
    .pix_valid_i              (pix_valid),
    .pix_ready_o              (pix_ready),
    .spi_screen_flush_data_o  (flush_data),
    .spi_screen_flush_updte_i (updte),
    .spi_screen_flush_fsync_i (fsync),
    .frame_done_o             (frame_done),
    .sof_err_o                (sof_err),
    .underflow_cnt_o          (uf_cnt),
    .err_clr_i                (err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic push(input logic sof, input logic [15:0] d);
    int t;
    t = 0;
    @(negedge sys_clk);
    while (!pix_ready && t < 20) begin
      @(negedge sys_clk);
      t++;
    end
    chk("push_rdy", pix_ready, 1);
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_data  = d;
    @(negedge sys_clk);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic upd(output logic fd);
    @(negedge sys_clk);
    updte = 1'b1;
    @(negedge sys_clk);
    updte = 1'b0;
    fd = frame_done;
    @(negedge sys_clk);
  endtask

  task automatic do_fsync(input int wait_n);
    @(negedge sys_clk);
    fsync = 1'b1;
    @(negedge sys_clk);
    fsync = 1'b0;
    idle(wait_n);
  endtask

  task automatic clr();
    @(negedge sys_clk);
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic fd;
    logic [7:0] e;
    logic [7:0] t1 [8];
    t1 = '{8'h00, 8'h07, 8'hE0, 8'h00,
           8'h1F, 8'hAB, 8'hCD, 8'hBE};

    idle(3);
    chk("rst_ready", pix_ready, 0);
    chk("rst_data", flush_data, 0);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("ready_after_rst", pix_ready, 1);
    chk("wait_data", flush_data, 8'hBE);
    chk("rst_uf", uf_cnt, 0);
    chk("rst_sof_err", sof_err, 0);
    chk("rst_fd", frame_done, 0);

    // 1: basic serialisation
    push(1'b1, 16'hF800);
    push(1'b0, 16'h07E0);
    push(1'b0, 16'h001F);
    push(1'b0, 16'hABCD);
    do_fsync(4);
    chk("t1_b0", flush_data, 8'hF8);
    for (int i = 0; i < 8; i++) begin
      upd(fd);
      chk("t1_byte", flush_data, t1[i]);
    end
    chk("t1_uf", uf_cnt, 1);
    clr();
    chk("t1_clr", uf_cnt, 0);

    // 2: full frame
    for (int k = 1; k <= 8; k++)
      push(k == 1, 16'(k * 16'h1111));
    do_fsync(4);
    chk("t2_midfsync_err", sof_err, 1);
    clr();
    chk("t2_b0", flush_data, 8'h11);
    for (int i = 1; i <= 16; i++) begin
      upd(fd);
      chk("t2_fd", fd, (i == 16));
      e = 8'(((i >> 1) + 1) * 8'h11);
      if (i < 16) chk("t2_byte", flush_data, e);
    end
    chk("t2_wait_data", flush_data, 8'hBE);
    upd(fd);
    chk("t2_ign_data", flush_data, 8'hBE);
    chk("t2_ign_uf", uf_cnt, 0);
    chk("t2_ign_fd", fd, 0);

    // 3: starvation
    do_fsync(4);
    chk("t3_no_err", sof_err, 0);
    chk("t3_b0", flush_data, 8'hBE);
    for (int i = 1; i <= 4; i++) begin
      upd(fd);
      chk("t3_byte", flush_data, (i % 2) ? 8'hEF : 8'hBE);
      if (i == 2) chk("t3_uf2", uf_cnt, 2);
    end
    chk("t3_uf4", uf_cnt, 3);
    clr();

    // 4: junk before sof is discarded
    push(1'b0, 16'hAAAA);
    push(1'b0, 16'hBBBB);
    push(1'b0, 16'hCCCC);
    push(1'b1, 16'h1234);
    push(1'b0, 16'h5678);
    do_fsync(8);
    chk("t4_err", sof_err, 1);
    clr();
    chk("t4_b0", flush_data, 8'h12);
    upd(fd);
    chk("t4_b1", flush_data, 8'h34);
    upd(fd);
    chk("t4_b2", flush_data, 8'h56);
    chk("t4_uf", uf_cnt, 0);

    // 5: early sof at pixel 3
    do_fsync(4);
    clr();
    for (int k = 1; k <= 8; k++)
      push(k == 1 || k == 4, 16'(k * 16'h1011));
    idle(2);
    chk("t5_b0", flush_data, 8'h10);
    for (int i = 1; i <= 16; i++) begin
      upd(fd);
      chk("t5_fd", fd, (i == 16));
      chk("t5_err", sof_err, (i >= 6));
      if (i < 16) begin
        if ((i >> 1) < 3)
          e = (i % 2) ? 8'(((i >> 1) + 1) * 8'h11)
                      : 8'(((i >> 1) + 1) << 4);
        else
          e = (i % 2) ? 8'hEF : 8'hBE;
        chk("t5_byte", flush_data, e);
      end
    end
    chk("t5_uf", uf_cnt, 0);
    do_fsync(4);
    chk("t5_realign", flush_data, 8'h40);
    upd(fd);
    chk("t5_ra1", flush_data, 8'h44);
    upd(fd);
    chk("t5_ra2", flush_data, 8'h50);
    clr();

    // 6a: fsync beats a same-cycle update
    @(negedge sys_clk);
    fsync = 1'b1;
    updte = 1'b1;
    @(negedge sys_clk);
    fsync = 1'b0;
    updte = 1'b0;
    idle(6);
    chk("t6_prio_data", flush_data, 8'h50);
    chk("t6_prio_err", sof_err, 1);
    chk("t6_prio_uf", uf_cnt, 0);
    clr();

    // 6b: clear beats a same-cycle underflow
    @(negedge sys_clk);
    updte   = 1'b1;
    err_clr = 1'b1;
    @(negedge sys_clk);
    updte   = 1'b0;
    err_clr = 1'b0;
    @(negedge sys_clk);
    chk("t6_clr_uf", uf_cnt, 0);
    chk("t6_clr_data", flush_data, 8'hEF);
    upd(fd);
    chk("t6_uf_evt", uf_cnt, 1);
    clr();
    chk("t6_uf_clr", uf_cnt, 0);

    // 6c: full FIFO refuses pushes
    for (int k = 1; k <= 8; k++)
      push(k == 1, 16'h9000 + 16'(k));
    chk("t6_full", pix_ready, 0);
    @(negedge sys_clk);
    pix_valid = 1'b1;
    pix_data  = 16'hDEAD;
    idle(3);
    pix_valid = 1'b0;
    chk("t6_full_hold", pix_ready, 0);
    do_fsync(4);
    clr();
    chk("t6_ready_back", pix_ready, 1);
    chk("t6_b0", flush_data, 8'h90);
    for (int i = 1; i <= 16; i++) begin
      upd(fd);
      chk("t6_fd", fd, (i == 16));
      e = (i % 2) ? 8'((i >> 1) + 1) : 8'h90;
      if (i < 16) chk("t6_byte", flush_data, e);
    end
    chk("t6_uf_end", uf_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
